// File: rtl/winograd_kernel_transform_2d.sv
// winograd_kernel_transform_2d: streams a 3x3 kernel in, emits U = G*g*G^T (6x6, scaled by 576).
// One shared 3->6 transform is reused for the column pass and then the row pass.
module winograd_kernel_transform_2d #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;
    typedef enum logic [1:0] {LOAD, COL, ROW, OUT} state_t;
    state_t state_q, state_d;
    logic [2:0] r_q, r_d, c_q, c_d;
    logic [W-1:0] g_q [3][3];
    logic [W-1:0] tmp_q [6][3];
    logic [W-1:0] u_q [6][6];
    logic [W-1:0] x0, x1, x2, s;
    logic [W-1:0] t [6];
    logic adv_c, adv_r, c_end, r_end, done;
    // COL feeds a kernel column, ROW feeds a row of the column-pass result
    always_comb begin
        x0 = state_q == COL ? g_q[0][c_q[1:0]] : tmp_q[r_q][0];
        x1 = state_q == COL ? g_q[1][c_q[1:0]] : tmp_q[r_q][1];
        x2 = state_q == COL ? g_q[2][c_q[1:0]] : tmp_q[r_q][2];
        s = x0 + x2;
        t[0] = (x0 << 2) + (x0 << 1);
        t[1] = '0 - ((s + x1) << 2);
        t[2] = '0 - ((s - x1) << 2);
        t[3] = x0 + (x1 << 1) + (x2 << 2);
        t[4] = x0 - (x1 << 1) + (x2 << 2);
        t[5] = (x2 << 4) + (x2 << 3);
    end
    // r/c walk the 3x3 input, the 3 columns, the 6 rows, then the 6x6 output
    always_comb begin
        c_end = c_q == (state_q == OUT ? 3'd5 : 3'd2);
        r_end = r_q == (state_q == LOAD ? 3'd2 : 3'd5);
        adv_c = (state_q == LOAD && in_valid) || state_q == COL || (state_q == OUT && out_ready);
        adv_r = state_q == ROW || (((state_q == LOAD && in_valid) || (state_q == OUT && out_ready)) && c_end);
        done = state_q == COL ? c_end : adv_r && r_end;
        c_d = adv_c ? (c_end ? 3'd0 : c_q + 3'd1) : c_q;
        r_d = adv_r ? (r_end ? 3'd0 : r_q + 3'd1) : r_q;
        state_d = !done ? state_q : state_q == LOAD ? COL : state_q == COL ? ROW : state_q == ROW ? OUT : LOAD;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            r_q <= '0;
            c_q <= '0;
            g_q <= '{default: '0};
            tmp_q <= '{default: '0};
            u_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            r_q <= r_d;
            c_q <= c_d;
            if (state_q == LOAD && in_valid) g_q[r_q[1:0]][c_q[1:0]] <= in_data;
            if (state_q == COL) for (int j = 0; j < 6; j++) tmp_q[j][c_q[1:0]] <= t[j];
            if (state_q == ROW) for (int j = 0; j < 6; j++) u_q[r_q][j] <= t[j];
        end
    end
    assign in_ready = state_q == LOAD;
    assign busy = state_q != LOAD;
    assign out_valid = state_q == OUT;
    assign out_last = out_valid && r_q == 3'd5 && c_q == 3'd5;
    assign out_data = out_valid ? u_q[r_q][c_q] : '0;
endmodule

// File: tb/tb_winograd_kernel_transform_2d.sv
// tb_winograd_kernel_transform_2d: scoreboard bench; expected U from an explicit G*g*G^T matrix model.
module tb_winograd_kernel_transform_2d;
    typedef logic [31:0] kern_t [9];
    typedef struct {logic [31:0] d; logic l;} exp_t;
    logic clk, rst, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic [31:0] in_data, out_data;
    exp_t sb [$];
    int checks, errors, ready_mode;
    int gm [6][3];
    logic stall, pl;
    logic [31:0] pd;
    exp_t e;

    winograd_kernel_transform_2d #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode[0];
        end
    end

    // monitor: pops the scoreboard on every output handshake and checks stall stability
    initial begin
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst) stall = 0;
            else begin
                if (stall) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b", out_valid, out_data, out_last, pd, pl);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_out: got data=%h with empty scoreboard", out_data);
                    end else begin
                        e = sb.pop_front();
                        if (out_data !== e.d || out_last !== e.l) begin
                            errors++;
                            $display("FAIL out_word: got data=%h last=%b, want data=%h last=%b", out_data, out_last, e.d, e.l);
                        end
                    end
                end
                stall = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end
        end
    end

    function automatic void push_kernel(input kern_t k);
        exp_t x;
        int s;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) begin
                s = 0;
                for (int p = 0; p < 3; p++)
                    for (int q = 0; q < 3; q++)
                        s += gm[i][p] * int'(k[p*3+q]) * gm[j][q];
                x.d = s;
                x.l = i == 5 && j == 5;
                sb.push_back(x);
            end
    endfunction

    task automatic put_word(input logic [31:0] w);
        int n = 0;
        in_data = w;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_kernel(input kern_t k);
        push_kernel(k);
        for (int w = 0; w < 9; w++) put_word(k[w]);
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL drain: got left=%0d valid=%b in_ready=%b busy=%b, want 0 0 1 0", sb.size(), out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got in_ready=%b valid=%b last=%b busy=%b, want 1 0 0 0", in_ready, out_valid, out_last, busy);
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 0", out_data);
        end
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_delta();
        kern_t k = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
        ready_mode = 1;
        send_kernel(k);
        drain();
    endtask

    task automatic test_ones();
        kern_t k = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        ready_mode = 1;
        send_kernel(k);
        drain();
    endtask

    task automatic test_wrap_stall();
        kern_t k = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF};
        ready_mode = 0;
        send_kernel(k);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || sb.size() != 36 || out_data !== 32'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL long_stall: got valid=%b left=%0d data=%h busy=%b, want 1 36 0 1", out_valid, sb.size(), out_data, busy);
        end
        ready_mode = 1;
        drain();
    endtask

    task automatic test_random_stall();
        kern_t k;
        for (int w = 0; w < 9; w++) k[w] = $urandom;
        ready_mode = 2;
        send_kernel(k);
        drain();
        ready_mode = 1;
    endtask

    task automatic test_back_to_back();
        kern_t k1, k2;
        int lat = 0;
        for (int w = 0; w < 9; w++) begin
            k1[w] = $urandom;
            k2[w] = $urandom_range(0, 15) - 7;
        end
        ready_mode = 1;
        push_kernel(k1);
        for (int w = 0; w < 9; w++) put_word(k1[w]);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat + 1 != 10) begin
            errors++;
            $display("FAIL latency: got first out_valid %0d cycles after 9th accept, want 10", lat + 1);
        end
        push_kernel(k2);
        put_word(k2[0]);
        checks++;
        if (sb.size() != 36) begin
            errors++;
            $display("FAIL early_accept: got %0d words pending at 2nd kernel accept, want 36", sb.size());
        end
        for (int w = 1; w < 9; w++) put_word(k2[w]);
        in_valid = 0;
        drain();
    endtask

    task automatic test_reset_mid();
        kern_t k;
        int n = 0;
        ready_mode = 1;
        for (int w = 0; w < 5; w++) put_word($urandom);
        in_valid = 0;
        rst = 1;
        #2;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_load: got in_ready=%b valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        @(posedge clk);
        #1;
        rst = 0;
        for (int w = 0; w < 9; w++) k[w] = $urandom;
        send_kernel(k);
        while (sb.size() != 16 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        rst = 1;
        #1;
        checks++;
        if (n >= 200 || in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_out: got in_ready=%b valid=%b busy=%b last=%b wait=%0d, want 1 0 0 0", in_ready, out_valid, busy, out_last, n);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 0;
        for (int w = 0; w < 9; w++) k[w] = $urandom;
        send_kernel(k);
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        gm = '{'{6, 0, 0}, '{-4, -4, -4}, '{-4, 4, -4}, '{1, 2, 4}, '{1, -2, 4}, '{0, 0, 24}};
        checks = 0;
        errors = 0;
        ready_mode = 1;
        in_valid = 0;
        in_data = 0;
        out_ready = 1;
        test_reset();
        test_delta();
        test_ones();
        test_wrap_stall();
        test_random_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
